jogo_unidade_controle: RTL and testbench
========================================

# jogo_unidade_controle

Parametrised control unit for the memory-sequence game datapath: a Moore FSM plus internal address, round and timeout counters. It plays rounds of growing length (round r checks positions 0..r) against the sequence memory, reports win, error or timeout, and restarts on `iniciar`. It sits between the input edge detector and the datapath (memory + register + comparator). It is the multi-round, parametrised successor of the single-pass control unit.

## Interface
- `ADDR_W`, 4: memory address width.
- `N_RODADAS`, 16: number of rounds; legal range 1..2^ADDR_W.
- `TIMEOUT`, 5000: clock cycles allowed per move; minimum 2.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start/restart request, level-sampled.
- `jogada`  in  1  one-cycle pulse: player entered a move.
- `chavesIgualMemoria`  in  1  comparator result, registered switch value vs `memoria[endereco]`.
- `endereco`  out  ADDR_W  memory address of the move under test.
- `zeraR`  out  1  clear datapath register.
- `registraR`  out  1  load datapath register.
- `pronto`  out  1  game over (any end state).
- `ganhou`  out  1  all rounds completed.
- `perdeu`  out  1  wrong move.
- `timeout`  out  1  move not entered in time.
- `db_rodada`  out  ADDR_W  current round index.
- `db_estado`  out  4  state code for 7-segment debug.

## Operation
- States and codes: inicial 0, preparacao 1, espera 3, registra 4, comparacao 5, proxima_jogada 6, proxima_rodada 7, fim_ganhou A, fim_timeout D, fim_perdeu E. Illegal codes drive `db_estado`=F and go to inicial.
- inicial: `iniciar`=1 -> preparacao, else stay.
- preparacao: `endereco`<=0, `db_rodada`<=0, timer<=0 -> espera.
- espera: `jogada`=1 -> registra; else timer expired -> fim_timeout; else stay. `jogada` wins over expiry in the same cycle.
- registra -> comparacao.
- comparacao: `chavesIgualMemoria`=0 -> fim_perdeu; else `endereco`==`db_rodada`: -> fim_ganhou if `db_rodada`==N_RODADAS-1, otherwise proxima_rodada; else -> proxima_jogada.
- proxima_jogada: `endereco`<=`endereco`+1 -> espera.
- proxima_rodada: `db_rodada`<=`db_rodada`+1, `endereco`<=0 -> espera.
- fim_*: hold; `iniciar`=1 -> preparacao (direct restart).
- Moore outputs: `zeraR`=1 in inicial and preparacao; `registraR`=1 in registra; `pronto`=1 in all fim_*; `ganhou`, `perdeu` and `timeout` are each 1 only in their own fim state.
- Timer: cleared in every state except espera; increments each cycle in espera; expired when timer==TIMEOUT-1. Width is $clog2(TIMEOUT). Counters never wrap, because the comparisons bound them.

## Timing
- Reset (asynchronous, while `reset`=0): state inicial, `endereco`=0, `db_rodada`=0, timer=0. Outputs: `zeraR`=1, `db_estado`=0, all others 0. Takes effect mid-operation from any state.
- `iniciar` high at edge k in inicial: preparacao after k, espera after k+1.
- `jogada` sampled at edge t in espera: registra after t, comparacao after t+1, next state after t+2. Minimum move spacing is 4 cycles; a `jogada` outside espera is ignored.
- `endereco` is stable from espera through comparacao, so the memory has 2 cycles to settle before the compare.
- Timeout: with no `jogada`, fim_timeout is entered TIMEOUT cycles after espera is entered.

## Configuration
- `JOGO_TIMEOUT_EN` defined: timer logic compiled in as described.
- `JOGO_TIMEOUT_EN` undefined: no timer; espera waits indefinitely; `timeout` is tied to 0; fim_timeout is unreachable, and its code D is decoded as illegal.

## Test plan
- N_RODADAS=4, TIMEOUT=20, all compares true, 10 moves (1+2+3+4) -> `ganhou`=1, `pronto`=1, `db_estado`=A, `db_rodada`=3.
- Round 2, `chavesIgualMemoria`=0 at `endereco`=1 -> fim_perdeu, `perdeu`=1, `db_estado`=E, `endereco`=1.
- No `jogada` for 20 cycles in espera -> `timeout`=1 exactly 20 cycles after espera entry. Repeat with `jogada` on the expiry cycle -> registra, no timeout.
- `reset`=0 asserted in comparacao of round 3 -> immediately inicial, `endereco`=0, `db_rodada`=0, `zeraR`=1.
- In fim_perdeu, pulse `iniciar` -> preparacao, then espera with counters zeroed. `jogada` pulses during registra/comparacao are ignored.
- Compiled without `JOGO_TIMEOUT_EN`: idle 1000 cycles in espera -> remains in espera, `timeout`=0.

Source files
------------

// File: rtl/jogo_unidade_controle.sv
// Multi-round control unit for the memory-sequence game: Moore FSM plus address, round and move-timer counters.
// Optional move timeout is compiled in when JOGO_TIMEOUT_EN is defined.
module jogo_unidade_controle #(
   parameter int ADDR_W    = 4,
   parameter int N_RODADAS = 16,
   parameter int TIMEOUT   = 5000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              jogada,
   input  logic              chavesIgualMemoria,
   output logic [ADDR_W-1:0] endereco,
   output logic              zeraR,
   output logic              registraR,
   output logic              pronto,
   output logic              ganhou,
   output logic              perdeu,
   output logic              timeout,
   output logic [ADDR_W-1:0] db_rodada,
   output logic [3:0]        db_estado
);

   localparam logic [3:0] INICIAL        = 4'h0;
   localparam logic [3:0] PREPARACAO     = 4'h1;
   localparam logic [3:0] ESPERA         = 4'h3;
   localparam logic [3:0] REGISTRA       = 4'h4;
   localparam logic [3:0] COMPARACAO     = 4'h5;
   localparam logic [3:0] PROXIMA_JOGADA = 4'h6;
   localparam logic [3:0] PROXIMA_RODADA = 4'h7;
   localparam logic [3:0] FIM_GANHOU     = 4'hA;
   localparam logic [3:0] FIM_TIMEOUT    = 4'hD;
   localparam logic [3:0] FIM_PERDEU     = 4'hE;
   localparam logic [3:0] ILEGAL         = 4'hF;

   localparam logic [ADDR_W-1:0] ULTIMA_RODADA = ADDR_W'(N_RODADAS - 1);

   logic [3:0]        estado_q, estado_d;
   logic [ADDR_W-1:0] endereco_q, endereco_d;
   logic [ADDR_W-1:0] rodada_q, rodada_d;
   logic              expirado_s;
   logic              fim_s;

`ifdef JOGO_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

   logic [TMR_W-1:0] timer_q, timer_d;

   assign expirado_s = (timer_q == TMR_MAX);

   // Move timer: counts only while waiting for a move, saturates at expiry, cleared elsewhere.
   always_comb begin
      timer_d = '0;
      if (estado_q == ESPERA) begin
         if (expirado_s) begin
            timer_d = timer_q;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
      end else begin
         timer_d = '0;
      end
   end

   // Timer register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign expirado_s = 1'b0;
`endif

   // Next-state logic; jogada takes priority over timer expiry.
   always_comb begin
      estado_d = INICIAL;
      case (estado_q)
         INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
         PREPARACAO:     estado_d = ESPERA;
         ESPERA: begin
            if (jogada) begin
               estado_d = REGISTRA;
            end else if (expirado_s) begin
               estado_d = FIM_TIMEOUT;
            end else begin
               estado_d = ESPERA;
            end
         end
         REGISTRA:       estado_d = COMPARACAO;
         COMPARACAO: begin
            if (!chavesIgualMemoria) begin
               estado_d = FIM_PERDEU;
            end else if (endereco_q == rodada_q) begin
               estado_d = (rodada_q == ULTIMA_RODADA) ? FIM_GANHOU : PROXIMA_RODADA;
            end else begin
               estado_d = PROXIMA_JOGADA;
            end
         end
         PROXIMA_JOGADA: estado_d = ESPERA;
         PROXIMA_RODADA: estado_d = ESPERA;
         FIM_GANHOU:     estado_d = iniciar ? PREPARACAO : FIM_GANHOU;
         FIM_PERDEU:     estado_d = iniciar ? PREPARACAO : FIM_PERDEU;
`ifdef JOGO_TIMEOUT_EN
         FIM_TIMEOUT:    estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
         default:        estado_d = INICIAL;
      endcase
   end

   // Address and round counters; comparacao bounds them so they never wrap.
   always_comb begin
      endereco_d = endereco_q;
      rodada_d   = rodada_q;
      case (estado_q)
         PREPARACAO: begin
            endereco_d = '0;
            rodada_d   = '0;
         end
         PROXIMA_JOGADA: begin
            endereco_d = endereco_q + ADDR_W'(1);
            rodada_d   = rodada_q;
         end
         PROXIMA_RODADA: begin
            endereco_d = '0;
            rodada_d   = rodada_q + ADDR_W'(1);
         end
         default: begin
            endereco_d = endereco_q;
            rodada_d   = rodada_q;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q   <= INICIAL;
         endereco_q <= '0;
         rodada_q   <= '0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         rodada_q   <= rodada_d;
      end
   end

   // Moore output decode; any unknown code reports F on the debug display.
   always_comb begin
      db_estado = estado_q;
      fim_s     = 1'b0;
      case (estado_q)
         INICIAL, PREPARACAO, ESPERA, REGISTRA, COMPARACAO,
         PROXIMA_JOGADA, PROXIMA_RODADA: begin
            db_estado = estado_q;
            fim_s     = 1'b0;
         end
`ifdef JOGO_TIMEOUT_EN
         FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
`else
         FIM_GANHOU, FIM_PERDEU: begin
`endif
            db_estado = estado_q;
            fim_s     = 1'b1;
         end
         default: begin
            db_estado = ILEGAL;
            fim_s     = 1'b0;
         end
      endcase
   end

   assign zeraR     = (estado_q == INICIAL) || (estado_q == PREPARACAO);
   assign registraR = (estado_q == REGISTRA);
   assign pronto    = fim_s;
   assign ganhou    = (estado_q == FIM_GANHOU);
   assign perdeu    = (estado_q == FIM_PERDEU);
`ifdef JOGO_TIMEOUT_EN
   assign timeout   = (estado_q == FIM_TIMEOUT);
`else
   assign timeout   = 1'b0;
`endif
   assign endereco  = endereco_q;
   assign db_rodada = rodada_q;

endmodule

// File: tb/tb_jogo_unidade_controle.sv
// Directed self-checking bench for jogo_unidade_controle (N_RODADAS=4, TIMEOUT=20).
// Timeout scenarios run when JOGO_TIMEOUT_EN is defined; otherwise the idle-forever scenario runs.
module tb_jogo_unidade_controle;

   localparam int ADDR_W = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              iniciar;
   logic              jogada;
   logic              chavesIgualMemoria;
   logic [ADDR_W-1:0] endereco;
   logic              zeraR;
   logic              registraR;
   logic              pronto;
   logic              ganhou;
   logic              perdeu;
   logic              timeout;
   logic [ADDR_W-1:0] db_rodada;
   logic [3:0]        db_estado;

   int checks_q = 0;
   int errors_q = 0;

   jogo_unidade_controle #(.ADDR_W(ADDR_W), .N_RODADAS(4), .TIMEOUT(20)) dut (
      .clock              (clock),
      .reset              (reset),
      .iniciar            (iniciar),
      .jogada             (jogada),
      .chavesIgualMemoria (chavesIgualMemoria),
      .endereco           (endereco),
      .zeraR              (zeraR),
      .registraR          (registraR),
      .pronto             (pronto),
      .ganhou             (ganhou),
      .perdeu             (perdeu),
      .timeout            (timeout),
      .db_rodada          (db_rodada),
      .db_estado          (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_q = checks_q + 1;
      if (got !== exp) begin
         errors_q = errors_q + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Enter a move from espera; extra jogada pulses in registra/comparacao must be ignored.
   task automatic move(input logic eq, input logic [3:0] exp_after);
      jogada = 1'b1;
      chavesIgualMemoria = eq;
      tick();
      check_eq("registra", 32'(db_estado), 32'h4);
      check_eq("registraR", 32'(registraR), 32'h1);
      tick();
      check_eq("comparacao", 32'(db_estado), 32'h5);
      jogada = 1'b0;
      tick();
      check_eq("after_cmp", 32'(db_estado), 32'(exp_after));
      chavesIgualMemoria = 1'b1;
   endtask

   task automatic start_game();
      iniciar = 1'b1;
      tick();
      check_eq("preparacao", 32'(db_estado), 32'h1);
      check_eq("prep_zeraR", 32'(zeraR), 32'h1);
      iniciar = 1'b0;
      tick();
      check_eq("espera", 32'(db_estado), 32'h3);
      check_eq("esp_zeraR", 32'(zeraR), 32'h0);
      check_eq("esp_end0", 32'(endereco), 32'h0);
      check_eq("esp_rod0", 32'(db_rodada), 32'h0);
   endtask

   // Correct moves for rounds 0..last_r; returns in espera of round last_r+1.
   task automatic play_rounds(input int last_r);
      for (int r = 0; r <= last_r; r++) begin
         for (int p = 0; p <= r; p++) begin
            check_eq("pos_end", 32'(endereco), 32'(p));
            check_eq("pos_rod", 32'(db_rodada), 32'(r));
            if (p < r) begin
               move(1'b1, 4'h6);
            end else if (r == 3) begin
               move(1'b1, 4'hA);
            end else begin
               move(1'b1, 4'h7);
            end
            if (!(p == r && r == 3)) begin
               tick();
               check_eq("back_espera", 32'(db_estado), 32'h3);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      iniciar = 1'b0;
      jogada = 1'b0;
      chavesIgualMemoria = 1'b1;
      tick();
      tick();
      check_eq("rst_estado", 32'(db_estado), 32'h0);
      check_eq("rst_zeraR", 32'(zeraR), 32'h1);
      check_eq("rst_out", 32'({registraR, pronto, ganhou, perdeu, timeout}), 32'h0);
      check_eq("rst_end", 32'(endereco), 32'h0);
      reset = 1'b1;
      tick();
      check_eq("idle_inicial", 32'(db_estado), 32'h0);

      // Full win: 10 correct moves.
      start_game();
      play_rounds(3);
      check_eq("win_ganhou", 32'(ganhou), 32'h1);
      check_eq("win_pronto", 32'(pronto), 32'h1);
      check_eq("win_rodada", 32'(db_rodada), 32'h3);
      check_eq("win_end", 32'(endereco), 32'h3);
      check_eq("win_perdeu", 32'(perdeu), 32'h0);
      tick();
      check_eq("win_hold", 32'(db_estado), 32'hA);

      // Wrong move at endereco 1 in round 2.
      start_game();
      play_rounds(1);
      check_eq("r2_rod", 32'(db_rodada), 32'h2);
      move(1'b1, 4'h6);
      tick();
      check_eq("r2_esp", 32'(db_estado), 32'h3);
      check_eq("r2_end", 32'(endereco), 32'h1);
      move(1'b0, 4'hE);
      check_eq("lose_perdeu", 32'(perdeu), 32'h1);
      check_eq("lose_pronto", 32'(pronto), 32'h1);
      check_eq("lose_ganhou", 32'(ganhou), 32'h0);
      check_eq("lose_end", 32'(endereco), 32'h1);
      jogada = 1'b1;
      tick();
      jogada = 1'b0;
      tick();
      check_eq("lose_hold", 32'(db_estado), 32'hE);

      // Direct restart from fim_perdeu.
      start_game();

      // Asynchronous reset in comparacao of round 3, endereco 2.
      play_rounds(2);
      move(1'b1, 4'h6);
      tick();
      move(1'b1, 4'h6);
      tick();
      check_eq("r3_end", 32'(endereco), 32'h2);
      jogada = 1'b1;
      tick();
      jogada = 1'b0;
      tick();
      check_eq("r3_cmp", 32'(db_estado), 32'h5);
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_estado", 32'(db_estado), 32'h0);
      check_eq("arst_end", 32'(endereco), 32'h0);
      check_eq("arst_rod", 32'(db_rodada), 32'h0);
      check_eq("arst_zeraR", 32'(zeraR), 32'h1);
      tick();
      reset = 1'b1;
      tick();

`ifdef JOGO_TIMEOUT_EN
      // Expiry exactly 20 cycles after espera entry.
      start_game();
      for (int i = 1; i <= 19; i++) begin
         tick();
         check_eq("to_wait", 32'({timeout, db_estado}), 32'h03);
      end
      tick();
      check_eq("to_estado", 32'(db_estado), 32'hD);
      check_eq("to_flag", 32'(timeout), 32'h1);
      check_eq("to_pronto", 32'(pronto), 32'h1);
      // jogada on the expiry cycle wins.
      start_game();
      for (int i = 1; i <= 19; i++) begin
         tick();
      end
      check_eq("to2_wait", 32'(db_estado), 32'h3);
      jogada = 1'b1;
      tick();
      jogada = 1'b0;
      check_eq("to2_reg", 32'(db_estado), 32'h4);
      check_eq("to2_flag", 32'(timeout), 32'h0);
`else
      // No timer: espera waits indefinitely.
      start_game();
      for (int i = 1; i <= 1000; i++) begin
         tick();
         if (i % 100 == 0) begin
            check_eq("idle_espera", 32'({timeout, pronto, db_estado}), 32'h003);
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
      $finish;
   end

endmodule
